main_memory: RTL and testbench

Block-granular backing memory behind `L2_cache`, serving its miss fills and write traffic. It accepts one request at a time on the L2 memory port (`mem_read`/`mem_write` with `mem_addr`) and returns a whole block on `mem_data_block`. `mem_ready` pulses after a fixed, parameterised latency. It is the terminal stage of the L1 → L2 → memory hierarchy.

---
 rtl/mem_pkg.sv | 19 +
 rtl/main_memory_if.sv | 29 ++
 rtl/mem_block_array.sv | 30 +++
 rtl/main_memory.sv | 113 +++++++++++
 tb/tb_main_memory.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the block-granular main memory and its L2 requester.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_BLOCK_SIZE = 32;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_OFFSET     = $clog2(DEF_BLOCK_SIZE);
    localparam int DEF_NUM_BLOCKS = 2 ** (DEF_ADDR_WIDTH - DEF_OFFSET);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_WIDTH-1:0] block_t;

endpackage

// File: rtl/main_memory_if.sv
// L2 <-> memory request/response bus: one request in flight, answered by a mem_ready strobe.
// Handshake: the master raises mem_read and/or mem_write with mem_addr/mem_data_in and holds
// them until it observes mem_ready, then drops them in the following cycle; mem_data_block is
// valid only while mem_ready is high, and mem_busy marks a request in flight.
interface main_memory_if #(
    parameter int DATA_WIDTH = mem_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_pkg::DEF_ADDR_WIDTH,
    parameter int BLOCK_SIZE = mem_pkg::DEF_BLOCK_SIZE
);

    logic [ADDR_WIDTH-1:0]                 mem_addr;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in;
    logic                                  mem_read;
    logic                                  mem_write;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block;
    logic                                  mem_ready;
    logic                                  mem_busy;

    modport master (
        output mem_addr, mem_data_in, mem_read, mem_write,
        input  mem_data_block, mem_ready, mem_busy
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_read, mem_write,
        output mem_data_block, mem_ready, mem_busy
    );

endinterface

// File: rtl/mem_block_array.sv
// Block storage: one block-wide synchronous write port, one asynchronous read port,
// whole array cleared to zero by reset.
module mem_block_array #(
    parameter int DATA_WIDTH = mem_pkg::DEF_DATA_WIDTH,
    parameter int BLOCK_SIZE = mem_pkg::DEF_BLOCK_SIZE,
    parameter int NUM_BLOCKS = mem_pkg::DEF_NUM_BLOCKS,
    parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  we_i,
    input  logic [IDX_W-1:0]                      widx_i,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]                      ridx_i,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata_o
);

    logic [NUM_BLOCKS-1:0][BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/main_memory.sv
// Block-granular backing memory: accepts one request, answers a fixed LATENCY edges later
// with a one-cycle mem_ready strobe and the whole block.
module main_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic          clk,
    input  logic          rst_n,
    main_memory_if.slave  bus,
    output mem_state_t    dbg_state_o
);

    localparam int OFFSET     = $clog2(BLOCK_SIZE);
    localparam int IDX_W      = ADDR_WIDTH - OFFSET;
    localparam int NUM_BLOCKS = 2 ** IDX_W;

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

    mem_state_t        state_q, state_d;
    logic [7:0]        cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              wr_q,    wr_d;
    blk_t              wdata_q, wdata_d;
    blk_t              rdata_q, rdata_d;
    blk_t              stored_blk;
    logic              commit;
    logic              unused_offset;

    assign unused_offset = ^bus.mem_addr[OFFSET-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // BUSY is always passed through, even at LATENCY==1, so mem_ready rises exactly
    // LATENCY edges after the accepting edge. The response block is loaded on entry to RESP
    // so it is valid for the whole mem_ready cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    idx_d   = bus.mem_addr[ADDR_WIDTH-1:OFFSET];
                    wr_d    = bus.mem_write;
                    wdata_d = bus.mem_data_in;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    rdata_d = wr_q ? wdata_q : stored_blk;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Writes land only at the edge closing RESP, so a reset before then leaves storage untouched.
    assign commit = (state_q == RESP) && wr_q;

    mem_block_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (commit),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .ridx_i  (idx_q),
        .rdata_o (stored_blk)
    );

    assign bus.mem_data_block = rdata_q;
    assign bus.mem_ready      = (state_q == RESP);
    assign bus.mem_busy       = (state_q != IDLE);
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: directed scenarios plus randomized traffic checked against an
// array-of-blocks reference memory, on a LATENCY=4 and a LATENCY=1 instance.
module tb_main_memory;
    import mem_pkg::*;

    localparam int NB = DEF_NUM_BLOCKS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    main_memory_if if4();
    main_memory_if if1();
    mem_state_t    st4, st1;

    main_memory #(.LATENCY(4)) u_mem4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave), .dbg_state_o(st4)
    );
    main_memory #(.LATENCY(1)) u_mem1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .dbg_state_o(st1)
    );

    int tests = 0;
    int fails = 0;
    int rdy4_cnt = 0;
    int rdy1_cnt = 0;
    block_t ref4 [NB];
    block_t ref1 [NB];
    block_t exp_q [$];

    always @(negedge clk) begin
        if (if4.mem_ready === 1'b1) rdy4_cnt++;
        if (if1.mem_ready === 1'b1) rdy1_cnt++;
    end

    function automatic block_t pat(input logic [31:0] base);
        block_t b;
        for (int i = 0; i < DEF_BLOCK_SIZE; i++) b[i] = base ^ 32'(i);
        return b;
    endfunction

    function automatic block_t rnd_blk();
        block_t b;
        for (int i = 0; i < DEF_BLOCK_SIZE; i++) b[i] = $urandom;
        return b;
    endfunction

    function automatic int first_diff(input block_t a, input block_t b);
        for (int i = 0; i < DEF_BLOCK_SIZE; i++) if (a[i] !== b[i]) return i;
        return 0;
    endfunction

    function automatic int bidx(input logic [10:0] a);
        return int'(a[10:5]);
    endfunction

    task automatic clear_models();
        for (int i = 0; i < NB; i++) begin
            ref4[i] = '0;
            ref1[i] = '0;
        end
    endtask

    task automatic idle_inputs();
        if4.mem_read = 0; if4.mem_write = 0; if4.mem_addr = '0; if4.mem_data_in = '0;
        if1.mem_read = 0; if1.mem_write = 0; if1.mem_addr = '0; if1.mem_data_in = '0;
    endtask

    // Drives one request from IDLE, waits (bounded) for mem_ready, returns the response,
    // the edge count from acceptance, and mem_ready one cycle later. lat = -1 on timeout.
    task automatic drive_req(input bit sel, input bit rd, input bit wr,
                             input logic [10:0] addr, input block_t data,
                             output block_t resp, output int lat, output logic rdy_after);
        @(negedge clk);
        if (sel) begin
            if1.mem_read = rd; if1.mem_write = wr; if1.mem_addr = addr; if1.mem_data_in = data;
        end else begin
            if4.mem_read = rd; if4.mem_write = wr; if4.mem_addr = addr; if4.mem_data_in = data;
        end
        lat = -1;
        resp = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if ((sel ? if1.mem_ready : if4.mem_ready) === 1'b1) begin
                lat = k;
                resp = sel ? if1.mem_data_block : if4.mem_data_block;
                break;
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        rdy_after = sel ? if1.mem_ready : if4.mem_ready;
    endtask

    task automatic test_reset();
        block_t r; int lat; logic ra;
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        clear_models();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tests++;
            if (if4.mem_ready !== 1'b0 || if4.mem_busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle_flags cycle %0d: ready=%b busy=%b want 0 0", c, if4.mem_ready, if4.mem_busy);
            end
            tests++;
            if (if4.mem_data_block !== '0) begin
                fails++;
                $display("FAIL reset_idle_data cycle %0d: word0=%h want 0", c, if4.mem_data_block[0]);
            end
        end
        tests++;
        if (st4 !== IDLE || st1 !== IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d/%0d want IDLE", st4, st1);
        end
        drive_req(0, 1, 0, 11'h000, '0, r, lat, ra);
        tests++;
        if (r !== '0) begin
            fails++;
            $display("FAIL reset_read0: word %0d got %h want 0", first_diff(r, '0), r[first_diff(r, '0)]);
        end
    endtask

    task automatic test_read_latency();
        block_t r; int lat; int k_rdy; int c0;
        c0 = rdy4_cnt;
        @(negedge clk);
        if4.mem_read = 1; if4.mem_addr = 11'h00A;
        @(posedge clk); #1;
        tests++;
        if (if4.mem_busy !== 1'b1 || st4 !== BUSY) begin
            fails++;
            $display("FAIL lat_busy_after_accept: busy=%b state=%0d want 1 BUSY", if4.mem_busy, st4);
        end
        k_rdy = -1;
        r = '0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            if (if4.mem_ready === 1'b1) begin
                k_rdy = k; r = if4.mem_data_block; break;
            end
        end
        tests++;
        if (k_rdy != 4) begin
            fails++;
            $display("FAIL read_latency: ready after %0d edges want 4", k_rdy);
        end
        tests++;
        if (r !== '0) begin
            fails++;
            $display("FAIL read_latency_data: word0=%h want 0", r[0]);
        end
        tests++;
        if (if4.mem_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_in_resp: got %b want 1", if4.mem_busy);
        end
        idle_inputs();
        @(posedge clk); #1;
        tests++;
        if (if4.mem_ready !== 1'b0 || if4.mem_busy !== 1'b0) begin
            fails++;
            $display("FAIL ready_one_cycle: ready=%b busy=%b want 0 0", if4.mem_ready, if4.mem_busy);
        end
        tests++;
        if (rdy4_cnt - c0 != 1) begin
            fails++;
            $display("FAIL read_latency_pulses: got %0d want 1", rdy4_cnt - c0);
        end
    endtask

    task automatic test_write_read();
        block_t d, r; int lat; logic ra;
        d = pat(32'hA5A5A5A5);
        drive_req(0, 0, 1, 11'h014, d, r, lat, ra);
        ref4[bidx(11'h014)] = d;
        tests++;
        if (lat != 4 || ra !== 1'b0) begin
            fails++;
            $display("FAIL write_latency: lat=%0d ready_after=%b want 4 0", lat, ra);
        end
        tests++;
        if (r !== d) begin
            fails++;
            $display("FAIL write_echo: word %0d got %h want %h", first_diff(r, d), r[first_diff(r, d)], d[first_diff(r, d)]);
        end
        drive_req(0, 1, 0, 11'h01F, '0, r, lat, ra);
        tests++;
        if (r[0] !== 32'hA5A5A5A5 || r[31] !== 32'hA5A5A5BA) begin
            fails++;
            $display("FAIL read_same_block: w0=%h w31=%h want a5a5a5a5 a5a5a5ba", r[0], r[31]);
        end
        tests++;
        if (r !== ref4[0]) begin
            fails++;
            $display("FAIL read_same_block_all: word %0d got %h", first_diff(r, ref4[0]), r[first_diff(r, ref4[0])]);
        end
        drive_req(0, 1, 0, 11'h020, '0, r, lat, ra);
        tests++;
        if (r !== '0) begin
            fails++;
            $display("FAIL read_block1: word0=%h want 0", r[0]);
        end
    endtask

    task automatic test_simultaneous();
        block_t d, r; int lat; logic ra;
        d = pat(32'h5A5A5A5A);
        drive_req(0, 1, 1, 11'h040, d, r, lat, ra);
        ref4[bidx(11'h040)] = d;
        tests++;
        if (r !== d) begin
            fails++;
            $display("FAIL rw_echo: word %0d got %h want %h", first_diff(r, d), r[first_diff(r, d)], d[first_diff(r, d)]);
        end
        drive_req(0, 1, 0, 11'h040, '0, r, lat, ra);
        tests++;
        if (r[3] !== 32'h5A5A5A59) begin
            fails++;
            $display("FAIL rw_readback: w3=%h want 5a5a5a59", r[3]);
        end
    endtask

    task automatic test_busy_ignore();
        block_t r, ones; int lat; int k_rdy; int c0; logic ra;
        ones = '1;
        c0 = rdy4_cnt;
        @(negedge clk);
        if4.mem_read = 1; if4.mem_addr = 11'h100; if4.mem_data_in = '0;
        @(posedge clk);
        @(negedge clk);
        if4.mem_read = 0; if4.mem_write = 1; if4.mem_addr = 11'h060; if4.mem_data_in = ones;
        @(negedge clk);
        if4.mem_read = 1; if4.mem_write = 0; if4.mem_addr = 11'h100; if4.mem_data_in = '0;
        k_rdy = -1;
        r = '1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (if4.mem_ready === 1'b1) begin
                k_rdy = k; r = if4.mem_data_block; break;
            end
        end
        idle_inputs();
        tests++;
        if (k_rdy < 0 || r !== ref4[bidx(11'h100)]) begin
            fails++;
            $display("FAIL busy_orig_resp: edges=%0d word0=%h want %h", k_rdy, r[0], ref4[bidx(11'h100)][0]);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (rdy4_cnt - c0 != 1) begin
            fails++;
            $display("FAIL busy_pulses: got %0d want 1", rdy4_cnt - c0);
        end
        drive_req(0, 1, 0, 11'h060, '0, r, lat, ra);
        tests++;
        if (r !== '0) begin
            fails++;
            $display("FAIL busy_ignored_write: word0=%h want 0", r[0]);
        end
    endtask

    task automatic test_random();
        block_t d, r, e; int lat; logic ra; logic [10:0] a; int op;
        for (int n = 0; n < 24; n++) begin
            a = {6'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            op = $urandom_range(0, 2);
            d = rnd_blk();
            if (op == 0) begin
                exp_q.push_back(ref4[bidx(a)]);
            end else begin
                ref4[bidx(a)] = d;
                exp_q.push_back(d);
            end
            drive_req(0, op != 1, op != 0, a, d, r, lat, ra);
            e = exp_q.pop_front();
            tests++;
            if (lat != 4) begin
                fails++;
                $display("FAIL rand_latency op %0d: got %0d want 4", n, lat);
            end
            tests++;
            if (r !== e) begin
                fails++;
                $display("FAIL rand_data op %0d addr %h: word %0d got %h want %h", n, a, first_diff(r, e), r[first_diff(r, e)], e[first_diff(r, e)]);
            end
        end
    endtask

    task automatic test_back_to_back();
        block_t d, r; int k_rdy; logic [10:0] a;
        a = 11'h1A3;
        d = rnd_blk();
        @(negedge clk);
        if4.mem_write = 1; if4.mem_addr = a; if4.mem_data_in = d;
        k_rdy = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (if4.mem_ready === 1'b1) begin k_rdy = k; break; end
        end
        ref4[bidx(a)] = d;
        if4.mem_write = 0; if4.mem_read = 1;
        tests++;
        if (k_rdy != 4) begin
            fails++;
            $display("FAIL b2b_write_latency: got %0d want 4", k_rdy);
        end
        k_rdy = -1;
        r = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (if4.mem_ready === 1'b1) begin k_rdy = k; r = if4.mem_data_block; break; end
        end
        idle_inputs();
        tests++;
        if (k_rdy != 5) begin
            fails++;
            $display("FAIL b2b_read_spacing: got %0d edges want 5", k_rdy);
        end
        tests++;
        if (r !== d) begin
            fails++;
            $display("FAIL b2b_read_data: word %0d got %h want %h", first_diff(r, d), r[first_diff(r, d)], d[first_diff(r, d)]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency1();
        block_t d, r; int lat; logic ra; logic [10:0] a;
        for (int n = 0; n < 4; n++) begin
            a = 11'($urandom_range(0, 2047));
            d = rnd_blk();
            drive_req(1, 0, 1, a, d, r, lat, ra);
            ref1[bidx(a)] = d;
            tests++;
            if (lat != 1 || ra !== 1'b0) begin
                fails++;
                $display("FAIL lat1_write: lat=%0d ready_after=%b want 1 0", lat, ra);
            end
            drive_req(1, 1, 0, a ^ 11'h01F, '0, r, lat, ra);
            tests++;
            if (lat != 1 || r !== ref1[bidx(a)]) begin
                fails++;
                $display("FAIL lat1_read: lat=%0d word0=%h want 1 %h", lat, r[0], ref1[bidx(a)][0]);
            end
        end
    endtask

    task automatic test_abort();
        block_t r; int lat; logic ra; int c0;
        c0 = rdy4_cnt;
        @(negedge clk);
        if4.mem_write = 1; if4.mem_addr = 11'h080; if4.mem_data_in = rnd_blk();
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 0;
        repeat (2) @(posedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        clear_models();
        repeat (8) @(posedge clk);
        #1;
        tests++;
        if (rdy4_cnt != c0 || if4.mem_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_ready: pulses=%0d busy=%b want 0 0", rdy4_cnt - c0, if4.mem_busy);
        end
        drive_req(0, 1, 0, 11'h080, '0, r, lat, ra);
        tests++;
        if (r !== '0 || lat != 4) begin
            fails++;
            $display("FAIL abort_read: word0=%h lat=%0d want 0 4", r[0], lat);
        end
    endtask

    initial begin
        idle_inputs();
        clear_models();
        test_reset();
        test_read_latency();
        test_write_read();
        test_simultaneous();
        test_busy_ignore();
        test_random();
        test_back_to_back();
        test_latency1();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
